// File: rtl/voice_alloc_if.sv
// voice_alloc_if
//   Key-side and codec-side signals of the voice allocator, bundled so that the
//   allocator and its bench share one definition.
//   slave  : the allocator (takes keys and increments, drives the codec side)
//   master : whoever drives the keys (board logic or the bench)
//   Signals:
//     iKEY        key levels, 1 = pressed, asynchronous to the clock
//     iKEY_INC    phase increment of key k at [16k+15:16k]
//     oKEY_ON     voice gates, bit v -> codec key(v+1)_on
//     oSOUND1..4  phase increments of voices 0..3
//     oBUSY       a press is pending or a voice is re-triggering
//     oSTEAL_CNT  number of voice steals, wraps
//     oDBG_VSTATE voice FSM states, 2 bits per voice, voice 0 in [1:0]
//     oDBG_SCAN   key index the scanner services this clock
//   Handshake: none. Every signal is a level; keys are sampled continuously
//   through a synchroniser and outputs are plain registered levels.
interface voice_alloc_if #(
  parameter int NKEYS = 8
);
  logic [NKEYS-1:0]    iKEY;
  logic [NKEYS*16-1:0] iKEY_INC;
  logic [3:0]          oKEY_ON;
  logic [15:0]         oSOUND1;
  logic [15:0]         oSOUND2;
  logic [15:0]         oSOUND3;
  logic [15:0]         oSOUND4;
  logic                oBUSY;
  logic [7:0]          oSTEAL_CNT;
  logic [7:0]          oDBG_VSTATE;
  logic [3:0]          oDBG_SCAN;

  modport master (
    output iKEY, iKEY_INC,
    input  oKEY_ON, oSOUND1, oSOUND2, oSOUND3, oSOUND4,
    input  oBUSY, oSTEAL_CNT, oDBG_VSTATE, oDBG_SCAN
  );

  modport slave (
    input  iKEY, iKEY_INC,
    output oKEY_ON, oSOUND1, oSOUND2, oSOUND3, oSOUND4,
    output oBUSY, oSTEAL_CNT, oDBG_VSTATE, oDBG_SCAN
  );
endinterface

// File: rtl/voice_alloc_ctrl.sv
// voice_alloc_ctrl
//   Shares the four tone-generator voices of adio_codec among NKEYS keys.
//   A press takes the lowest free voice, or steals the oldest sounding voice
//   (which is then silenced for RETRIG_CYC clocks before re-gating). A release
//   frees the voice the key owns. One key is serviced per clock by a
//   free-running scanner.
//   Ports:
//     iCLK_18_4  18.432 MHz system clock
//     iRST_N     asynchronous active-low reset
//     bus        voice_alloc_if.slave (keys in, codec gates/increments out)
module voice_alloc_ctrl #(
  parameter int NKEYS      = 8,
  parameter int RETRIG_CYC = 384,
  parameter int AGE_W      = 16
) (
  input  logic         iCLK_18_4,
  input  logic         iRST_N,
  voice_alloc_if.slave bus
);
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int RW = $clog2(RETRIG_CYC + 1);
  localparam logic [KW-1:0]    LAST_KEY    = KW'(NKEYS - 1);
  localparam logic [RW-1:0]    RETRIG_LAST = RW'(RETRIG_CYC - 1);
  localparam logic [AGE_W-1:0] AGE_MAX     = '1;

  typedef enum logic [1:0] {
    V_IDLE   = 2'd0,
    V_ON     = 2'd1,
    V_RETRIG = 2'd2
  } vstate_t;

  logic [NKEYS-1:0] r_sync1, r_sync2, r_prev;
  logic [NKEYS-1:0] r_pend_on, r_pend_off;
  logic [KW-1:0]    r_scan_idx;
  vstate_t          r_state [4];
  logic [KW-1:0]    r_owner [4];
  logic [AGE_W-1:0] r_age   [4];
  logic [RW-1:0]    r_rcnt  [4];
  logic [15:0]      r_sound [4];
  logic [3:0]       r_gate;
  logic             r_busy;
  logic [7:0]       r_steal_cnt;

  logic [NKEYS-1:0] w_rise, w_fall, w_owns;
  logic [NKEYS-1:0] w_pend_on_nx, w_pend_off_nx;
  logic             w_any_retrig;
  logic             w_idle_any, w_on_any, w_own_cur;
  logic [1:0]       w_idle_v, w_old_v, w_own_v;
  logic [AGE_W-1:0] w_old_age;
  logic             w_do_rel, w_do_alloc, w_do_steal;
  logic             w_clr_on, w_clr_off;
  logic [1:0]       w_tgt_v;
  logic [15:0]      w_key_inc;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_fall    = ~r_sync2 & r_prev;
  assign w_key_inc = bus.iKEY_INC[int'(r_scan_idx)*16 +: 16];

  // Which keys currently own a voice (ON or RETRIG).
  always_comb begin
    w_owns       = '0;
    w_any_retrig = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (r_state[v] != V_IDLE)   w_owns[r_owner[v]] = 1'b1;
      if (r_state[v] == V_RETRIG) w_any_retrig = 1'b1;
    end
  end

  // Voice candidates for the key at the scan pointer.
  always_comb begin
    w_idle_any = 1'b0;
    w_idle_v   = '0;
    w_on_any   = 1'b0;
    w_old_v    = '0;
    w_old_age  = '0;
    w_own_cur  = 1'b0;
    w_own_v    = '0;
    // Descending so the lowest-index idle voice is the one left selected.
    for (int v = 3; v >= 0; v--) begin
      if (r_state[v] == V_IDLE) begin
        w_idle_any = 1'b1;
        w_idle_v   = 2'(v);
      end
    end
    // Strict '>' keeps the lowest index on equal ages.
    for (int v = 0; v < 4; v++) begin
      if (r_state[v] == V_ON && (!w_on_any || r_age[v] > w_old_age)) begin
        w_on_any  = 1'b1;
        w_old_v   = 2'(v);
        w_old_age = r_age[v];
      end
    end
    for (int v = 0; v < 4; v++) begin
      if (r_state[v] != V_IDLE && r_owner[v] == r_scan_idx) begin
        w_own_cur = 1'b1;
        w_own_v   = 2'(v);
      end
    end
  end

  // Service decision for the scanned key. A press whose release edge arrives
  // this very clock is treated as already cancelled, so a short tap never
  // allocates or steals.
  always_comb begin
    w_do_rel   = 1'b0;
    w_do_alloc = 1'b0;
    w_do_steal = 1'b0;
    w_clr_on   = 1'b0;
    w_clr_off  = 1'b0;
    w_tgt_v    = '0;
    if (r_pend_off[r_scan_idx]) begin
      w_clr_off = 1'b1;
      if (w_own_cur) begin
        w_do_rel = 1'b1;
        w_tgt_v  = w_own_v;
      end
    end else if (r_pend_on[r_scan_idx] && !w_fall[r_scan_idx]) begin
      if (w_own_cur) begin
        w_clr_on = 1'b1;
      end else if (w_idle_any) begin
        w_do_alloc = 1'b1;
        w_tgt_v    = w_idle_v;
        w_clr_on   = 1'b1;
      end else if (w_on_any) begin
        w_do_steal = 1'b1;
        w_tgt_v    = w_old_v;
        w_clr_on   = 1'b1;
      end
    end
  end

  // Pending bits: scanner clears first, new edges on the same clock win.
  always_comb begin
    w_pend_on_nx  = r_pend_on;
    w_pend_off_nx = r_pend_off;
    if (w_clr_on)  w_pend_on_nx[r_scan_idx]  = 1'b0;
    if (w_clr_off) w_pend_off_nx[r_scan_idx] = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      if (w_rise[k]) begin
        w_pend_on_nx[k]  = 1'b1;
        w_pend_off_nx[k] = 1'b0;
      end else if (w_fall[k]) begin
        w_pend_off_nx[k] = 1'b1;
        if (!w_owns[k]) w_pend_on_nx[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      // Key history resets to "held" so a key held through reset produces no
      // rising edge; it must be released and pressed again.
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_prev      <= '1;
      r_pend_on   <= '0;
      r_pend_off  <= '0;
      r_scan_idx  <= '0;
      r_gate      <= '0;
      r_busy      <= 1'b0;
      r_steal_cnt <= '0;
      for (int v = 0; v < 4; v++) begin
        r_state[v] <= V_IDLE;
        r_owner[v] <= '0;
        r_age[v]   <= '0;
        r_rcnt[v]  <= '0;
        r_sound[v] <= '0;
      end
    end else begin
      r_sync1    <= bus.iKEY;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_pend_on  <= w_pend_on_nx;
      r_pend_off <= w_pend_off_nx;
      r_scan_idx <= (r_scan_idx == LAST_KEY) ? '0 : r_scan_idx + 1'b1;
      r_busy     <= (|r_pend_on) | w_any_retrig;
      if (w_do_steal) r_steal_cnt <= r_steal_cnt + 1'b1;

      for (int v = 0; v < 4; v++) begin
        case (r_state[v])
          V_ON: begin
            if (r_age[v] != AGE_MAX) r_age[v] <= r_age[v] + 1'b1;
          end
          V_RETRIG: begin
            if (r_rcnt[v] == RETRIG_LAST) begin
              r_state[v] <= V_ON;
              r_gate[v]  <= 1'b1;
            end else begin
              r_rcnt[v] <= r_rcnt[v] + 1'b1;
            end
          end
          default: ;
        endcase

        // Scanner actions override the free-running updates above.
        if (w_tgt_v == 2'(v)) begin
          if (w_do_rel) begin
            r_state[v] <= V_IDLE;
            r_gate[v]  <= 1'b0;
          end
          if (w_do_alloc) begin
            r_owner[v] <= r_scan_idx;
            r_sound[v] <= w_key_inc;
            r_age[v]   <= '0;
            r_state[v] <= V_ON;
            r_gate[v]  <= 1'b1;
          end
          if (w_do_steal) begin
            r_owner[v] <= r_scan_idx;
            r_sound[v] <= w_key_inc;
            r_age[v]   <= '0;
            r_rcnt[v]  <= '0;
            r_state[v] <= V_RETRIG;
            r_gate[v]  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.oKEY_ON     = r_gate;
  assign bus.oSOUND1     = r_sound[0];
  assign bus.oSOUND2     = r_sound[1];
  assign bus.oSOUND3     = r_sound[2];
  assign bus.oSOUND4     = r_sound[3];
  assign bus.oBUSY       = r_busy;
  assign bus.oSTEAL_CNT  = r_steal_cnt;
  assign bus.oDBG_VSTATE = {r_state[3], r_state[2], r_state[1], r_state[0]};
  assign bus.oDBG_SCAN   = 4'(r_scan_idx);
endmodule

// File: tb/tb_voice_alloc_ctrl.sv
module tb_voice_alloc_ctrl;
  localparam int NKEYS = 8;
  localparam int W     = 77;  // {key_on[4], sound1..4[64], steal[8], busy[1]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voice_alloc_if #(.NKEYS(NKEYS)) bus ();

  voice_alloc_ctrl #(.NKEYS(NKEYS), .RETRIG_CYC(384), .AGE_W(16)) dut (
    .iCLK_18_4 (clk),
    .iRST_N    (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic [7:0]  keys;
    logic [3:0]  on;
    logic [63:0] snd;
    logic [7:0]  steal;
    logic        busy;
  } vec_t;
  vec_t tbl[5];

  // ---------------- reference model (voice bookkeeping) ----------------
  int          m_owner[4];
  int          m_st[4];     // 0 idle, 1 sounding, 2 silenced after steal
  int          m_seq[4];    // order in which voices started sounding
  logic [15:0] m_snd[4];
  bit          m_held[NKEYS];
  int          m_steals;
  int          m_seq_ctr;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] e);
    check({tag, " key_on"}, 32'(bus.oKEY_ON),    32'(e[76:73]));
    check({tag, " sound1"}, 32'(bus.oSOUND1),    32'(e[72:57]));
    check({tag, " sound2"}, 32'(bus.oSOUND2),    32'(e[56:41]));
    check({tag, " sound3"}, 32'(bus.oSOUND3),    32'(e[40:25]));
    check({tag, " sound4"}, 32'(bus.oSOUND4),    32'(e[24:9]));
    check({tag, " steal"},  32'(bus.oSTEAL_CNT), 32'(e[8:1]));
    check({tag, " busy"},   32'(bus.oBUSY),      32'(e[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_keys(input logic [7:0] k);
    @(posedge clk);
    #1;
    bus.iKEY = k;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line up with the scanner so simultaneous presses are serviced key 0 first.
  task automatic align_scan();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (bus.oDBG_SCAN == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("scan align", 32'(found), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- model tasks ----------------
  task automatic m_reset();
    for (int v = 0; v < 4; v++) begin
      m_owner[v] = -1;
      m_st[v]    = 0;
      m_seq[v]   = 0;
      m_snd[v]   = '0;
    end
    for (int k = 0; k < NKEYS; k++) m_held[k] = 1'b0;
    m_steals  = 0;
    m_seq_ctr = 0;
  endtask

  task automatic m_press(input int k, output int stolen_v);
    int best;
    stolen_v  = -1;
    m_held[k] = 1'b1;
    for (int v = 0; v < 4; v++) begin
      if (m_st[v] == 0) begin
        m_owner[v] = k;
        m_snd[v]   = 16'(100 * (k + 1));
        m_st[v]    = 1;
        m_seq[v]   = m_seq_ctr++;
        return;
      end
    end
    best = -1;
    for (int v = 0; v < 4; v++)
      if (m_st[v] == 1 && (best < 0 || m_seq[v] < m_seq[best])) best = v;
    if (best >= 0) begin
      m_owner[best] = k;
      m_snd[best]   = 16'(100 * (k + 1));
      m_st[best]    = 2;
      m_steals++;
      stolen_v = best;
    end
  endtask

  task automatic m_release(input int k);
    m_held[k] = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (m_st[v] != 0 && m_owner[v] == k) begin
        m_st[v]    = 0;
        m_owner[v] = -1;
      end
    end
  endtask

  task automatic m_push();
    logic [3:0] on;
    logic       busy;
    on   = '0;
    busy = 1'b0;
    for (int v = 0; v < 4; v++) begin
      on[v] = (m_st[v] == 1);
      if (m_st[v] == 2) busy = 1'b1;
    end
    exp_q.push_back({on, m_snd[0], m_snd[1], m_snd[2], m_snd[3], 8'(m_steals), busy});
  endtask

  task automatic sb_compare(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " queue empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_outs(tag, e);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] cur;
    int lat, n, stolen_v, k;
    bit seen, bad;

    bus.iKEY = '0;
    for (int i = 0; i < NKEYS; i++) bus.iKEY_INC[16*i +: 16] = 16'(100 * (i + 1));

    tbl[0] = '{keys: 8'h04, on: 4'b0001, snd: {16'd300, 16'd0,   16'd0,   16'd0},   steal: 8'd0, busy: 1'b0};
    tbl[1] = '{keys: 8'h00, on: 4'b0000, snd: {16'd300, 16'd0,   16'd0,   16'd0},   steal: 8'd0, busy: 1'b0};
    tbl[2] = '{keys: 8'h0F, on: 4'b1111, snd: {16'd100, 16'd200, 16'd300, 16'd400}, steal: 8'd0, busy: 1'b0};
    tbl[3] = '{keys: 8'h07, on: 4'b0111, snd: {16'd100, 16'd200, 16'd300, 16'd400}, steal: 8'd0, busy: 1'b0};
    tbl[4] = '{keys: 8'h0F, on: 4'b1111, snd: {16'd100, 16'd200, 16'd300, 16'd400}, steal: 8'd0, busy: 1'b0};

    // Reset state
    wait_neg(3);
    check_outs("reset", {4'b0, 64'd0, 8'd0, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_neg(20);

    // T1/T2: table of key patterns with latency and output checks
    for (int i = 0; i < 5; i++) begin
      align_scan();
      bus.iKEY = tbl[i].keys;
      lat = 0;
      for (lat = 0; lat < 24; lat++) begin
        @(negedge clk);
        if (bus.oKEY_ON == tbl[i].on) break;
      end
      check($sformatf("row%0d latency %0d", i, lat), 32'(lat >= 4 && lat <= NKEYS + 4), 32'd1);
      wait_neg(16);
      check_outs($sformatf("row%0d", i), {tbl[i].on, tbl[i].snd, tbl[i].steal, tbl[i].busy});
    end
    cur = 8'h0F;

    // T3: steal the oldest voice (voice 0) with key 5
    repeat (1000) @(posedge clk);
    cur = 8'h2F;
    drive_keys(cur);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.oKEY_ON[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check("T3 steal seen", 32'(seen), 32'd1);
    check_outs("T3 retrig", {4'b1110, 16'd600, 16'd200, 16'd300, 16'd400, 8'd1, 1'b1});
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.oKEY_ON[0]) break;
      n++;
    end
    check("T3 retrig length", 32'(n), 32'd384);
    check("T3 regate", 32'(bus.oKEY_ON), 32'hF);
    wait_neg(16);
    cur = 8'h2E;   // release key 0, which lost its voice
    drive_keys(cur);
    wait_neg(16);
    check_outs("T3 stale release", {4'b1111, 16'd600, 16'd200, 16'd300, 16'd400, 8'd1, 1'b0});

    // T4: key 6 steals voice 1, then releases inside the retrig window
    cur = 8'h6E;
    drive_keys(cur);
    wait_neg(16);
    check_outs("T4 steal", {4'b1101, 16'd600, 16'd700, 16'd300, 16'd400, 8'd2, 1'b1});
    cur = 8'h2E;
    drive_keys(cur);
    wait_neg(16);
    check_outs("T4 release", {4'b1101, 16'd600, 16'd700, 16'd300, 16'd400, 8'd2, 1'b0});
    wait_neg(400);
    check("T4 gate stays low", 32'(bus.oKEY_ON), 32'hD);

    // T5: fill voice 1 with key 7, then one-clock taps of key 4 at several phases
    cur = 8'hAE;
    drive_keys(cur);
    wait_neg(16);
    check_outs("T5 fill", {4'b1111, 16'd600, 16'd800, 16'd300, 16'd400, 8'd2, 1'b0});
    for (int p = 0; p < 8; p++) begin
      repeat (p) @(posedge clk);
      drive_keys(cur | 8'h10);
      drive_keys(cur);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.oKEY_ON != 4'hF) bad = 1'b1;
      end
      check($sformatf("T5 tap%0d gates", p), 32'(bad), 32'd0);
      check($sformatf("T5 tap%0d steal", p), 32'(bus.oSTEAL_CNT), 32'd2);
    end

    // T6: key 0 steals voice 2 (oldest), then reset mid-retrig
    cur = 8'hAF;
    drive_keys(cur);
    wait_neg(16);
    check_outs("T6 steal", {4'b1011, 16'd600, 16'd800, 16'd100, 16'd400, 8'd3, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("T6 async reset", {4'b0, 64'd0, 8'd0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_neg(40);
    check_outs("T6 held ignored", {4'b0, 64'd0, 8'd0, 1'b0});
    cur = 8'hA7;
    drive_keys(cur);
    wait_neg(16);
    check("T6 release no-op", 32'(bus.oKEY_ON), 32'h0);
    cur = 8'hAF;
    drive_keys(cur);
    wait_neg(16);
    check_outs("T6 repress", {4'b0001, 16'd400, 16'd0, 16'd0, 16'd0, 8'd0, 1'b0});

    // Randomized presses/releases against the reference model
    cur = 8'h00;
    drive_keys(cur);
    pulse_reset();
    wait_neg(20);
    m_reset();
    for (int e = 0; e < 40; e++) begin
      k = $urandom_range(0, NKEYS - 1);
      stolen_v = -1;
      if (m_held[k]) begin
        m_release(k);
        cur[k] = 1'b0;
      end else begin
        m_press(k, stolen_v);
        cur[k] = 1'b1;
      end
      drive_keys(cur);
      wait_neg(16);
      m_push();
      sb_compare($sformatf("rnd%0d k%0d", e, k));
      if (stolen_v >= 0) begin
        wait_neg(390);
        m_st[stolen_v]  = 1;
        m_seq[stolen_v] = m_seq_ctr++;
        m_push();
        sb_compare($sformatf("rnd%0d regate", e));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
